// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, valid/ready byte output.
// Every state element advances only on ena; the consumer accept clears rx_valid on any cycle.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int BAUD_RATE  = 115_200,
    parameter int CLK_FREQ   = 50_000_000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ena,
    input  logic                  rx_signal,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
    localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
    localparam int CNT_WIDTH        = $clog2(PULSE_WIDTH) + 1;
    localparam int BIT_W            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_WIDTH-1:0] FULL_LOAD = CNT_WIDTH'(PULSE_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] HALF_LOAD = CNT_WIDTH'(HALF_PULSE_WIDTH - 1);
    localparam logic [BIT_W-1:0]     LAST_BIT  = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BRK   = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_sync1;
    logic                  r_sync2;
    logic [CNT_WIDTH-1:0]  r_timer;
    logic [BIT_W-1:0]      r_bitcnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_ferr;
    logic                  r_ovr;

    logic w_tick;
    logic w_free;

    assign w_tick = (r_timer == '0);
    // The output slot counts as free when this cycle's accept empties it.
    assign w_free = !r_valid || rx_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_timer  <= '0;
            r_bitcnt <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            if (r_valid && rx_ready)
                r_valid <= 1'b0;

            if (ena) begin
                r_sync1 <= rx_signal;
                r_sync2 <= r_sync1;

                case (r_state)
                    S_IDLE: begin
                        if (!r_sync2) begin
                            r_state <= S_START;
                            r_timer <= HALF_LOAD;
                        end
                    end
                    S_START: begin
                        if (w_tick) begin
                            if (!r_sync2) begin
                                r_state  <= S_DATA;
                                r_timer  <= FULL_LOAD;
                                r_bitcnt <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_timer <= r_timer - CNT_WIDTH'(1);
                        end
                    end
                    S_DATA: begin
                        if (w_tick) begin
                            r_shift[r_bitcnt] <= r_sync2;
                            r_timer           <= FULL_LOAD;
                            if (r_bitcnt == LAST_BIT)
                                r_state <= S_STOP;
                            else
                                r_bitcnt <= r_bitcnt + BIT_W'(1);
                        end else begin
                            r_timer <= r_timer - CNT_WIDTH'(1);
                        end
                    end
                    S_STOP: begin
                        // Leaving at mid-stop lets the next start edge follow immediately.
                        if (w_tick) begin
                            if (r_sync2) begin
                                r_state <= S_IDLE;
                                if (w_free) begin
                                    r_data  <= r_shift;
                                    r_valid <= 1'b1;
                                end else begin
                                    r_ovr <= 1'b1;
                                end
                            end else begin
                                r_ferr  <= 1'b1;
                                r_state <= S_BRK;
                            end
                        end else begin
                            r_timer <= r_timer - CNT_WIDTH'(1);
                        end
                    end
                    S_BRK: begin
                        if (r_sync2)
                            r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: good frames, glitch, framing error,
// overrun, mid-frame reset and ena gating.
module tb_uart_rx;

    localparam int P = 16;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       ena       = 1'b1;
    logic       rx_signal = 1'b1;
    logic       rx_ready  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int n_cmp   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int n_vrise = 0;
    int n_vcyc  = 0;
    int n_ferr  = 0;
    int n_ovr   = 0;
    int t_valid = -1;
    int t_start = 0;
    int ena_mode = 0;
    logic [7:0] got = 8'h00;
    logic prev_v = 1'b0;
    int b_v, b_vc, b_f, b_o;

    uart_rx #(
        .DATA_WIDTH(8),
        .BAUD_RATE (1),
        .CLK_FREQ  (16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ena      (ena),
        .rx_signal(rx_signal),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled just after each active edge.
    always @(posedge clk) begin
        #1;
        if (rx_valid && !prev_v) begin
            n_vrise++;
            t_valid = cyc;
            got     = rx_data;
        end
        if (rx_valid)  n_vcyc++;
        if (frame_err) n_ferr++;
        if (overrun)   n_ovr++;
        prev_v = rx_valid;
    end

    always @(negedge clk) begin
        case (ena_mode)
            1:       ena = ~ena;
            2:       ena = 1'b0;
            default: ena = 1'b1;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopb, input int per, input int stop_len);
        rx_signal = 1'b0;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_signal = d[i];
            repeat (per) @(negedge clk);
        end
        rx_signal = stopb;
        repeat (stop_len) @(negedge clk);
        rx_signal = 1'b1;
    endtask

    task automatic snap();
        b_v  = n_vrise;
        b_vc = n_vcyc;
        b_f  = n_ferr;
        b_o  = n_ovr;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rx_data", 32'(rx_data), 32'h0);
        chk("reset_rx_valid", 32'(rx_valid), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Plain frame, consumer always ready
        snap();
        t_valid = -1;
        t_start = cyc;
        send_frame(8'hA5, 1'b1, P, P);
        repeat (4) @(negedge clk);
        chk("t1_frames", 32'(n_vrise - b_v), 32'd1);
        chk("t1_data", 32'(got), 32'hA5);
        chk("t1_valid_cycles", 32'(n_vcyc - b_vc), 32'd1);
        chk("t1_latency", 32'(t_valid - t_start - 1), 32'd154);
        chk("t1_ferr", 32'(n_ferr - b_f), 32'd0);
        chk("t1_ovr", 32'(n_ovr - b_o), 32'd0);

        // Short low glitch, then a real frame
        snap();
        rx_signal = 1'b0;
        repeat (4) @(negedge clk);
        rx_signal = 1'b1;
        repeat (30) @(negedge clk);
        chk("t2_glitch_frames", 32'(n_vrise - b_v), 32'd0);
        chk("t2_glitch_ferr", 32'(n_ferr - b_f), 32'd0);
        send_frame(8'h3C, 1'b1, P, P);
        repeat (4) @(negedge clk);
        chk("t2_frames", 32'(n_vrise - b_v), 32'd1);
        chk("t2_data", 32'(got), 32'h3C);

        // Stop bit low followed by a long break, then a good frame
        snap();
        send_frame(8'h55, 1'b0, P, 4 * P);
        chk("t3_ferr_pulses", 32'(n_ferr - b_f), 32'd1);
        chk("t3_no_frame", 32'(n_vrise - b_v), 32'd0);
        repeat (2 * P) @(negedge clk);
        send_frame(8'h81, 1'b1, P, P);
        repeat (4) @(negedge clk);
        chk("t3_frames", 32'(n_vrise - b_v), 32'd1);
        chk("t3_data", 32'(got), 32'h81);
        chk("t3_ferr_total", 32'(n_ferr - b_f), 32'd1);

        // Back-to-back frames with the consumer stalled
        snap();
        rx_ready = 1'b0;
        send_frame(8'h01, 1'b1, P, P);
        send_frame(8'hFE, 1'b1, P, P);
        repeat (4) @(negedge clk);
        chk("t4_frames", 32'(n_vrise - b_v), 32'd1);
        chk("t4_valid_held", 32'(rx_valid), 32'd1);
        chk("t4_data_kept", 32'(rx_data), 32'h01);
        chk("t4_ovr_pulses", 32'(n_ovr - b_o), 32'd1);
        chk("t4_ferr", 32'(n_ferr - b_f), 32'd0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("t4_accept", 32'(rx_valid), 32'd0);

        // Reset three data bits into a frame of all ones
        rx_ready = 1'b1;
        snap();
        rx_signal = 1'b0;
        repeat (P) @(negedge clk);
        rx_signal = 1'b1;
        repeat (3 * P) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("t5_rx_data", 32'(rx_data), 32'h0);
        chk("t5_rx_valid", 32'(rx_valid), 32'h0);
        chk("t5_frame_err", 32'(frame_err), 32'h0);
        chk("t5_overrun", 32'(overrun), 32'h0);
        repeat (6 * P) @(negedge clk);
        chk("t5_no_frame", 32'(n_vrise - b_v), 32'd0);
        chk("t5_no_flags", 32'(n_ferr - b_f + n_ovr - b_o), 32'd0);
        send_frame(8'h7E, 1'b1, P, P);
        repeat (4) @(negedge clk);
        chk("t5_frames", 32'(n_vrise - b_v), 32'd1);
        chk("t5_data", 32'(got), 32'h7E);

        // ena at half rate with a doubled bit period, then a long freeze
        snap();
        rx_ready = 1'b0;
        ena_mode = 1;
        send_frame(8'hC3, 1'b1, 2 * P, 2 * P);
        repeat (8) @(negedge clk);
        chk("t6_frames", 32'(n_vrise - b_v), 32'd1);
        chk("t6_data", 32'(got), 32'hC3);
        ena_mode = 2;
        repeat (2) @(negedge clk);
        rx_signal = 1'b0;
        repeat (100) @(negedge clk);
        rx_signal = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_frz_valid", 32'(rx_valid), 32'd1);
        chk("t6_frz_data", 32'(rx_data), 32'hC3);
        chk("t6_frz_state", 32'(dut.r_state), 32'd0);
        chk("t6_frz_flags", 32'(n_ferr - b_f + n_ovr - b_o), 32'd0);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        chk("t6_accept_no_ena", 32'(rx_valid), 32'd0);
        ena_mode = 0;
        repeat (40) @(negedge clk);
        chk("t6_resume_frames", 32'(n_vrise - b_v), 32'd1);
        chk("t6_resume_ferr", 32'(n_ferr - b_f), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
